execute_hazard_unit: RTL and testbench
======================================

EXECUTE_HAZARD_UNIT -- requirements
Module: execute_hazard_unit

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning.
- WORD_WIDTH, 32, datapath word width.
- REGISTER_INDEX_WIDTH, 5, register index width.
- MUL_LATENCY, 5, total execute cycles of a multiply, including the start cycle; legal range 2..15.
- PERF_WIDTH, 16, width of the stall performance counter.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- ex_start_in, in, 1, one-cycle pulse: a new non-NOP instruction has entered execute.
- ex_is_mul_in, in, 1, execute instruction is a multiply.
- ex_d_cache_access_in, in, 1, execute instruction accesses the data cache.
- ex_mem_to_reg_in, in, 1, execute instruction is a load.
- ex_reg_write_in, in, 1, execute instruction writes a register.
- ex_dest_reg_in, in, REGISTER_INDEX_WIDTH, destination register of the execute instruction.
- id_rs1_in, in, REGISTER_INDEX_WIDTH, decode source register 1.
- id_rs2_in, in, REGISTER_INDEX_WIDTH, decode source register 2.
- id_uses_rs1_in, in, 1, decode instruction reads rs1.
- id_uses_rs2_in, in, 1, decode instruction reads rs2.
- d_cache_ready_in, in, 1, data cache has completed the access.
- branch_taken_in, in, 1, execute resolved a taken branch this cycle.
- execution_empty_out, out, 1, execute can accept a new instruction.
- stall_out, out, 1, hold decode/fetch.
- set_nop_out, out, 1, squash the decode-to-execute register to NOP.
- stall_cycles_out, out, PERF_WIDTH, saturating count of cycles with stall_out=1.

Function
REQ-003 The FSM SHALL have four states: IDLE, MUL_BUSY, MEM_WAIT, FLUSH.
REQ-004 In IDLE, when ex_start_in=1:
- ex_is_mul_in=1: go to MUL_BUSY and load the down-counter with MUL_LATENCY-2.
- else ex_d_cache_access_in=1 and d_cache_ready_in=0: go to MEM_WAIT.
- else: stay in IDLE (single-cycle op, or cache hit in the start cycle).
REQ-005 In MUL_BUSY the counter SHALL decrement each cycle; the FSM SHALL move to IDLE on the edge where the counter is 0. A multiply therefore holds execute for exactly MUL_LATENCY cycles, start cycle included.
REQ-006 In MEM_WAIT the FSM SHALL stay until d_cache_ready_in=1, then go to IDLE on that edge.
REQ-007 branch_taken_in=1 SHALL force FLUSH on the next edge from any state, overriding ex_start_in and all other transitions.
REQ-008 FLUSH SHALL last exactly one cycle and then go to IDLE, unless branch_taken_in=1 again, in which case it stays in FLUSH.
REQ-009 execution_empty_out SHALL be 1 only in IDLE.
REQ-010 set_nop_out SHALL be 1 only in FLUSH.
REQ-011 Outputs SHALL be registered or decoded from state only, except stall_out.
REQ-012 hazard SHALL be true when all of the following hold:
- ex_reg_write_in=1 and ex_mem_to_reg_in=1;
- ex_dest_reg_in != 0;
- (id_uses_rs1_in=1 and id_rs1_in == ex_dest_reg_in) or (id_uses_rs2_in=1 and id_rs2_in == ex_dest_reg_in).
REQ-013 stall_out SHALL be combinational and equal (hazard AND (state != IDLE OR ex_start_in)) OR state == MUL_BUSY OR state == MEM_WAIT.
REQ-014 stall_out SHALL be 0 in FLUSH and while reset_n=0.
REQ-015 stall_cycles_out SHALL increment by 1 on each rising edge where stall_out=1, and SHALL saturate at all-ones with no wrap-around.
REQ-016 Register 0 SHALL never create a hazard.
REQ-017 ex_start_in asserted outside IDLE SHALL be ignored; no state change results from it.

Reset
REQ-018 When reset_n=0, the block SHALL asynchronously reset to:
- state IDLE, counter 0;
- execution_empty_out=1, set_nop_out=0, stall_out=0, stall_cycles_out=0.
REQ-019 Reset asserted mid-multiply or mid-cache-wait SHALL abandon the operation immediately. After reset_n rises, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Multiply, MUL_LATENCY=5: ex_start_in with ex_is_mul_in=1 -> execution_empty_out=0 and stall_out=1 for exactly 4 further cycles, IDLE on the 5th edge; stall_cycles_out=4.
- Load-use: load to r7 starts, decode id_rs2_in=7 with id_uses_rs2_in=1, d_cache_ready_in low 3 cycles -> stall_out high throughout MEM_WAIT, execution_empty_out returns to 1 the edge after ready; a load to r0 with id_rs1_in=0 -> no hazard stall.
- Branch during MEM_WAIT: branch_taken_in pulse -> FLUSH next edge, set_nop_out=1 for exactly 1 cycle, stall_out=0 in FLUSH, then IDLE; back-to-back branch pulses -> set_nop_out stays 1.
- Simultaneous ex_start_in (multiply) and branch_taken_in in IDLE -> FLUSH, not MUL_BUSY.
- Saturation, PERF_WIDTH=4: 20 consecutive stall cycles -> stall_cycles_out holds at 15.
- Reset: reset_n low for 1 ns at MUL_BUSY counter=2 -> all outputs at reset values immediately, no clock needed; after release, the next multiply takes the full MUL_LATENCY.

Source files
------------

// File: rtl/execute_hazard_unit_if.sv
// Execute-stage hazard handshake: execute/decode status in, stall/flush control out.
interface execute_hazard_unit_if #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int PERF_WIDTH           = 16
);
  logic                            ex_start_in;
  logic                            ex_is_mul_in;
  logic                            ex_d_cache_access_in;
  logic                            ex_mem_to_reg_in;
  logic                            ex_reg_write_in;
  logic [REGISTER_INDEX_WIDTH-1:0] ex_dest_reg_in;
  logic [REGISTER_INDEX_WIDTH-1:0] id_rs1_in;
  logic [REGISTER_INDEX_WIDTH-1:0] id_rs2_in;
  logic                            id_uses_rs1_in;
  logic                            id_uses_rs2_in;
  logic                            d_cache_ready_in;
  logic                            branch_taken_in;
  logic                            execution_empty_out;
  logic                            stall_out;
  logic                            set_nop_out;
  logic [PERF_WIDTH-1:0]           stall_cycles_out;

  modport master (
    output ex_start_in, ex_is_mul_in, ex_d_cache_access_in, ex_mem_to_reg_in,
           ex_reg_write_in, ex_dest_reg_in, id_rs1_in, id_rs2_in,
           id_uses_rs1_in, id_uses_rs2_in, d_cache_ready_in, branch_taken_in,
    input  execution_empty_out, stall_out, set_nop_out, stall_cycles_out
  );

  modport slave (
    input  ex_start_in, ex_is_mul_in, ex_d_cache_access_in, ex_mem_to_reg_in,
           ex_reg_write_in, ex_dest_reg_in, id_rs1_in, id_rs2_in,
           id_uses_rs1_in, id_uses_rs2_in, d_cache_ready_in, branch_taken_in,
    output execution_empty_out, stall_out, set_nop_out, stall_cycles_out
  );
endinterface

// File: rtl/execute_hazard_unit.sv
// Execute-stage occupancy FSM (multiply / cache wait / branch flush), load-use
// hazard detection, and a saturating stall-cycle counter.
module execute_hazard_unit #(
  parameter int WORD_WIDTH           = 32,
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int MUL_LATENCY          = 5,
  parameter int PERF_WIDTH           = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  execute_hazard_unit_if.slave  hz
);
  localparam int CW = 4;

  generate
    if (MUL_LATENCY < 2 || MUL_LATENCY > 15 || WORD_WIDTH < REGISTER_INDEX_WIDTH) begin : g_bad_param
      $error("execute_hazard_unit: illegal parameterisation");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL_BUSY, S_MEM_WAIT, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0] perf_q;
  logic                  hazard;
  logic                  stall;

  always_comb begin
    hazard = hz.ex_reg_write_in && hz.ex_mem_to_reg_in &&
             (hz.ex_dest_reg_in != '0) &&
             ((hz.id_uses_rs1_in && (hz.id_rs1_in == hz.ex_dest_reg_in)) ||
              (hz.id_uses_rs2_in && (hz.id_rs2_in == hz.ex_dest_reg_in)));
  end

  // Branch flush overrides everything, including a start in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.branch_taken_in) begin
      state_d = S_FLUSH;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hz.ex_start_in) begin
            if (hz.ex_is_mul_in) begin
              state_d = S_MUL_BUSY;
              cnt_d   = CW'(MUL_LATENCY - 2);
            end else if (hz.ex_d_cache_access_in && !hz.d_cache_ready_in) begin
              state_d = S_MEM_WAIT;
            end
          end
        end
        S_MUL_BUSY: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_MEM_WAIT: if (hz.d_cache_ready_in) state_d = S_IDLE;
        S_FLUSH:    state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset_n so the stall drops the instant reset asserts.
  always_comb begin
    stall = reset_n && (state_q != S_FLUSH) &&
            ((hazard && ((state_q != S_IDLE) || hz.ex_start_in)) ||
             (state_q == S_MUL_BUSY) || (state_q == S_MEM_WAIT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      perf_q <= '0;
    else if (stall && (perf_q != '1))  perf_q <= perf_q + PERF_WIDTH'(1);
  end

  assign hz.execution_empty_out = (state_q == S_IDLE);
  assign hz.set_nop_out         = (state_q == S_FLUSH);
  assign hz.stall_out           = stall;
  assign hz.stall_cycles_out    = perf_q;
endmodule

// File: tb/tb_execute_hazard_unit.sv
// Directed scoreboard bench for execute_hazard_unit (MUL_LATENCY=5, PERF_WIDTH=4).
module tb_execute_hazard_unit;
  localparam int RIW = 5;
  localparam int PW  = 4;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string         tag;
    logic          empty;
    logic          stall;
    logic          nop;
    logic [PW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];

  execute_hazard_unit_if #(.REGISTER_INDEX_WIDTH(RIW), .PERF_WIDTH(PW)) hz ();

  execute_hazard_unit #(
    .WORD_WIDTH(32), .REGISTER_INDEX_WIDTH(RIW), .MUL_LATENCY(5), .PERF_WIDTH(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hz(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    hz.ex_start_in = 0; hz.ex_is_mul_in = 0; hz.ex_d_cache_access_in = 0;
    hz.ex_mem_to_reg_in = 0; hz.ex_reg_write_in = 0; hz.ex_dest_reg_in = '0;
    hz.id_rs1_in = '0; hz.id_rs2_in = '0; hz.id_uses_rs1_in = 0;
    hz.id_uses_rs2_in = 0; hz.d_cache_ready_in = 0; hz.branch_taken_in = 0;
  endtask

  task automatic push_exp(string tag, logic e, logic s, logic n, logic [PW-1:0] c);
    exp_t x;
    x.tag = tag; x.empty = e; x.stall = s; x.nop = n; x.cnt = c;
    sbq.push_back(x);
  endtask

  task automatic sample();
    exp_t x;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++; $error("FAIL scoreboard: got empty queue, required entry");
    end
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      checks++;
      assert (hz.execution_empty_out === x.empty) else begin
        errors++; $error("FAIL %s empty: got %b required %b", x.tag, hz.execution_empty_out, x.empty);
      end
      checks++;
      assert (hz.stall_out === x.stall) else begin
        errors++; $error("FAIL %s stall: got %b required %b", x.tag, hz.stall_out, x.stall);
      end
      checks++;
      assert (hz.set_nop_out === x.nop) else begin
        errors++; $error("FAIL %s nop: got %b required %b", x.tag, hz.set_nop_out, x.nop);
      end
      checks++;
      assert (hz.stall_cycles_out === x.cnt) else begin
        errors++; $error("FAIL %s cnt: got %0d required %0d", x.tag, hz.stall_cycles_out, x.cnt);
      end
    end
  endtask

  // Called at posedge+1 with inputs driven; samples mid-cycle, ends at next posedge+1.
  task automatic step(string tag, logic e, logic s, logic n, logic [PW-1:0] c);
    push_exp(tag, e, s, n, c);
    #4;
    sample();
    @(posedge clk); #1;
  endtask

  // Short asynchronous reset pulse; outputs checked while reset is low, no clock edge.
  task automatic pulse_reset(string tag);
    clr();
    reset_n = 0;
    #1;
    push_exp(tag, 1'b1, 1'b0, 1'b0, '0);
    sample();
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic run_mul(string tag);
    hz.ex_start_in = 1; hz.ex_is_mul_in = 1;
    step(tag, 1, 0, 0, 0);
    clr();
    for (int i = 1; i <= 4; i++) step(tag, 0, 1, 0, PW'(i - 1));
    step(tag, 1, 0, 0, 4);
  endtask

  initial begin
    clr();
    reset_n = 0;
    hz.ex_start_in = 1; hz.ex_is_mul_in = 1;
    #3;
    push_exp("reset", 1, 0, 0, 0);
    sample();
    clr();
    @(posedge clk); #1;
    reset_n = 1;

    // multiply: four further busy cycles
    run_mul("mul");

    // load-use on r7 through rs2, three cycles of cache miss
    pulse_reset("rst_pre_load");
    hz.ex_start_in = 1; hz.ex_d_cache_access_in = 1; hz.ex_mem_to_reg_in = 1;
    hz.ex_reg_write_in = 1; hz.ex_dest_reg_in = 7; hz.id_rs2_in = 7; hz.id_uses_rs2_in = 1;
    step("load_start", 1, 1, 0, 0);
    hz.ex_start_in = 0;
    step("load_wait1", 0, 1, 0, 1);
    step("load_wait2", 0, 1, 0, 2);
    hz.d_cache_ready_in = 1;
    step("load_ready", 0, 1, 0, 3);
    hz.d_cache_ready_in = 0;
    step("load_done", 1, 0, 0, 4);
    clr();
    // load to r0 never hazards
    hz.ex_start_in = 1; hz.ex_d_cache_access_in = 1; hz.ex_mem_to_reg_in = 1;
    hz.ex_reg_write_in = 1; hz.ex_dest_reg_in = 0; hz.id_rs1_in = 0; hz.id_uses_rs1_in = 1;
    hz.d_cache_ready_in = 1;
    step("load_r0", 1, 0, 0, 4);
    // matching rs2 but not used
    hz.ex_dest_reg_in = 7; hz.id_rs1_in = 2; hz.id_rs2_in = 7; hz.id_uses_rs2_in = 0;
    step("rs2_unused", 1, 0, 0, 4);
    // rs1 match with a cache hit: stall only in the start cycle
    hz.ex_dest_reg_in = 3; hz.id_rs1_in = 3; hz.id_uses_rs1_in = 1;
    step("rs1_hit", 1, 1, 0, 4);
    clr();
    step("rs1_after", 1, 0, 0, 5);

    // branch during a cache wait, then back-to-back branches
    pulse_reset("rst_pre_br");
    hz.ex_start_in = 1; hz.ex_d_cache_access_in = 1;
    step("br_start", 1, 0, 0, 0);
    hz.ex_start_in = 0;
    step("br_memwait", 0, 1, 0, 0);
    hz.branch_taken_in = 1;
    step("br_pulse", 0, 1, 0, 1);
    clr();
    hz.ex_mem_to_reg_in = 1; hz.ex_reg_write_in = 1; hz.ex_dest_reg_in = 5;
    hz.id_rs1_in = 5; hz.id_uses_rs1_in = 1;
    step("br_flush", 0, 0, 1, 2);
    clr();
    hz.branch_taken_in = 1;
    step("br_idle", 1, 0, 0, 2);
    step("br_flush2", 0, 0, 1, 2);
    hz.branch_taken_in = 0;
    step("br_flush3", 0, 0, 1, 2);
    step("br_back", 1, 0, 0, 2);

    // start(multiply) coincident with branch in IDLE
    hz.ex_start_in = 1; hz.ex_is_mul_in = 1; hz.branch_taken_in = 1;
    step("mulbr", 1, 0, 0, 2);
    clr();
    step("mulbr_flush", 0, 0, 1, 2);
    step("mulbr_idle", 1, 0, 0, 2);

    // saturation of the 4-bit stall counter
    pulse_reset("rst_pre_sat");
    hz.ex_start_in = 1; hz.ex_d_cache_access_in = 1;
    step("sat_start", 1, 0, 0, 0);
    hz.ex_start_in = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) hz.d_cache_ready_in = 1;
      step("sat", 0, 1, 0, (i - 1 < 15) ? PW'(i - 1) : PW'(15));
    end
    clr();
    step("sat_hold", 1, 0, 0, 15);

    // reset mid-multiply at counter=2, then a full-length multiply
    pulse_reset("rst_pre_mulrst");
    hz.ex_start_in = 1; hz.ex_is_mul_in = 1;
    step("mulrst_start", 1, 0, 0, 0);
    clr();
    step("mulrst_c3", 0, 1, 0, 0);
    pulse_reset("mulrst_async");
    run_mul("mul_after_rst");

    checks++;
    assert (sbq.size() == 0) else begin
      errors++; $error("FAIL scoreboard_drain: got %0d left, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
